// File: rtl/ball_pkg.sv
// Shared types and constants for the bouncing-ball engine.
package ball_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ERASE = 3'd1,
      ST_WAIT  = 3'd2,
      ST_MOVE  = 3'd3,
      ST_DRAW  = 3'd4,
      ST_DONE  = 3'd5
   } ball_state_t;

   localparam logic DIR_POS = 1'b1;
   localparam logic DIR_NEG = 1'b0;

   localparam logic [2:0] COLOR_BLACK = 3'd0;
   localparam logic [2:0] COLOR_FIRST = 3'd1;
   localparam logic [2:0] COLOR_LAST  = 3'd6;

   function automatic logic [2:0] next_color(input logic [2:0] c);
      return (c == COLOR_LAST) ? COLOR_FIRST : c + 3'd1;
   endfunction

endpackage

// File: rtl/ball_engine_if.sv
// Sequencer-facing bundle of the ball engine: frame request, paddle column and pixel-write outputs.
interface ball_engine_if;
   // go is a level request sampled only while idle; busy stays high until the frame
   // returns to idle; done pulses once on the last frame cycle; plot qualifies x/y/color.
   logic       go;
   logic [7:0] paddle_x;
   logic [7:0] x_out;
   logic [6:0] y_out;
   logic [2:0] color_out;
   logic       plot;
   logic       busy;
   logic       done;
   logic       hit;
   logic       miss;

   modport master (
      output go, paddle_x,
      input  x_out, y_out, color_out, plot, busy, done, hit, miss
   );

   modport slave (
      input  go, paddle_x,
      output x_out, y_out, color_out, plot, busy, done, hit, miss
   );
endinterface

// File: rtl/ball_sweep.sv
// Row-major SIZE x SIZE pixel index; held at zero while start is high, advances otherwise.
module ball_sweep #(
   parameter  int SIZE = 4,
   localparam int IW   = (SIZE > 1) ? $clog2(SIZE) : 1
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          start,
   output logic [IW-1:0] row,
   output logic [IW-1:0] col,
   output logic          last
);

   localparam logic [IW-1:0] MAX = IW'(SIZE - 1);

   assign last = (row == MAX) && (col == MAX);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         row <= '0;
         col <= '0;
      end else if (start) begin
         row <= '0;
         col <= '0;
      end else if (col == MAX) begin
         col <= '0;
         row <= last ? '0 : row + IW'(1);
      end else begin
         col <= col + IW'(1);
      end
   end

endmodule

// File: rtl/ball_engine.sv
// Single-ball erase/wait/move/draw engine with wall and paddle bounces.
// Optional macro BALL_SPEEDUP_EN: paddle hits halve the move period down to MIN_DIV.
module ball_engine
   import ball_pkg::*;
#(
   parameter int SIZE     = 4,
   parameter int SCR_W    = 160,
   parameter int SCR_H    = 120,
   parameter int PADDLE_Y = 109,
   parameter int PADDLE_W = 16,
   parameter int MOVE_DIV = 10_000_000,
   parameter int MIN_DIV  = 1_250_000,
   parameter int X_INIT   = 50,
   parameter int Y_INIT   = 60
) (
   input  logic         clk,
   input  logic         resetn,
   ball_engine_if.slave bus,
   output ball_state_t  state_dbg
);

   localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1;
   // Period counter sized for whichever divider is larger.
   localparam int PW = $clog2(((MOVE_DIV > MIN_DIV) ? MOVE_DIV : MIN_DIV) + 1);

   localparam logic [8:0] SIZE9 = 9'(SIZE);
   localparam logic [8:0] SCRW9 = 9'(SCR_W);
   localparam logic [8:0] SCRH9 = 9'(SCR_H);
   localparam logic [8:0] PADY9 = 9'(PADDLE_Y);
   localparam logic [8:0] PADW9 = 9'(PADDLE_W);
   localparam logic [7:0] XI    = 8'(X_INIT);
   localparam logic [6:0] YI    = 7'(Y_INIT);

   ball_state_t   state;
   logic [7:0]    bx;
   logic [6:0]    by;
   logic          dx;
   logic          dy;
   logic [2:0]    col_q;
   logic [PW-1:0] wait_cnt;
   logic [PW-1:0] per;
   logic          busy_q;
   logic          done_q;

   logic          sweep_on;
   logic          sw_start;
   logic [IW-1:0] sw_row;
   logic [IW-1:0] sw_col;
   logic          sw_last;

   logic [8:0]    bx9;
   logic [8:0]    by9;
   logic [8:0]    px9;
   logic          x_wall;
   logic          p_hit;
   logic          y_miss;

   ball_sweep #(.SIZE(SIZE)) u_sweep (
      .clk    (clk),
      .resetn (resetn),
      .start  (sw_start),
      .row    (sw_row),
      .col    (sw_col),
      .last   (sw_last)
   );

   assign sweep_on = (state == ST_ERASE) || (state == ST_DRAW);
   assign sw_start = !sweep_on;

   // Edge tests run in 9 bits so bx+SIZE and paddle_x+PADDLE_W never wrap.
   assign bx9    = {1'b0, bx};
   assign by9    = {2'b00, by};
   assign px9    = {1'b0, bus.paddle_x};
   assign x_wall = (bx9 + SIZE9) >= SCRW9;
   assign p_hit  = (dy == DIR_POS) && ((by9 + SIZE9) == PADY9) &&
                   ((bx9 + SIZE9) > px9) && (bx9 < (px9 + PADW9));
   assign y_miss = (dy == DIR_POS) && !p_hit && ((by9 + SIZE9) >= SCRH9);

`ifdef BALL_SPEEDUP_EN
   logic [PW-1:0] per_half;
   assign per_half = per >> 1;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         per <= PW'(MOVE_DIV);
      end else if (state == ST_MOVE) begin
         if (p_hit)
            per <= (per_half > PW'(MIN_DIV)) ? per_half : PW'(MIN_DIV);
         else if (y_miss)
            per <= PW'(MOVE_DIV);
      end
   end
`else
   assign per = PW'(MOVE_DIV);
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= ST_IDLE;
         bx       <= XI;
         by       <= YI;
         dx       <= DIR_POS;
         dy       <= DIR_POS;
         col_q    <= COLOR_FIRST;
         wait_cnt <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.go) begin
                  state  <= ST_ERASE;
                  busy_q <= 1'b1;
               end
            end
            ST_ERASE: begin
               if (sw_last) begin
                  state    <= ST_WAIT;
                  wait_cnt <= '0;
               end
            end
            ST_WAIT: begin
               if (wait_cnt == per - PW'(1))
                  state <= ST_MOVE;
               else
                  wait_cnt <= wait_cnt + PW'(1);
            end
            ST_MOVE: begin
               state <= ST_DRAW;
               // A miss respawns the ball and overrides this cycle's x step.
               if (y_miss) begin
                  bx <= XI;
                  by <= YI;
                  dy <= DIR_NEG;
               end else begin
                  if (dx == DIR_POS) begin
                     if (x_wall) begin
                        dx <= DIR_NEG;
                        bx <= bx - 8'd1;
                     end else begin
                        bx <= bx + 8'd1;
                     end
                  end else if (bx == 8'd0) begin
                     dx <= DIR_POS;
                     bx <= 8'd1;
                  end else begin
                     bx <= bx - 8'd1;
                  end

                  if (dy == DIR_NEG) begin
                     if (by == 7'd0) begin
                        dy <= DIR_POS;
                        by <= 7'd1;
                     end else begin
                        by <= by - 7'd1;
                     end
                  end else if (p_hit) begin
                     dy <= DIR_NEG;
                     by <= by - 7'd1;
                  end else begin
                     by <= by + 7'd1;
                  end
               end
            end
            ST_DRAW: begin
               if (sw_last) begin
                  state  <= ST_DONE;
                  done_q <= 1'b1;
               end
            end
            ST_DONE: begin
               state  <= ST_IDLE;
               busy_q <= 1'b0;
               col_q  <= next_color(col_q);
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.x_out     = sweep_on ? bx + 8'(sw_col) : bx;
   assign bus.y_out     = sweep_on ? by + 7'(sw_row) : by;
   assign bus.color_out = (state == ST_DRAW) ? col_q : COLOR_BLACK;
   assign bus.plot      = sweep_on;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.hit       = (state == ST_MOVE) && p_hit;
   assign bus.miss      = (state == ST_MOVE) && y_miss;
   assign state_dbg     = state;

endmodule

// File: tb/tb_ball_engine.sv
// Directed bench for ball_engine: reset, frame timing/pixels, walls, paddle, colours, speed-up.
module tb_ball_engine;
   import ball_pkg::*;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int sel = 0;

   ball_engine_if ifa ();
   ball_engine_if ifc ();
   ball_engine_if ifd ();
   ball_engine_if ife ();
   ball_state_t st_a, st_c, st_d, st_e;

   ball_engine #(.SIZE(4), .MOVE_DIV(4)) dut_a (
      .clk(clk), .resetn(resetn), .bus(ifa), .state_dbg(st_a));
   ball_engine #(.SIZE(4), .MOVE_DIV(1), .X_INIT(156), .Y_INIT(10)) dut_c (
      .clk(clk), .resetn(resetn), .bus(ifc), .state_dbg(st_c));
   ball_engine #(.SIZE(4), .MOVE_DIV(1), .SCR_W(8), .X_INIT(3), .Y_INIT(10)) dut_d (
      .clk(clk), .resetn(resetn), .bus(ifd), .state_dbg(st_d));
   ball_engine #(.SIZE(4), .MOVE_DIV(8), .MIN_DIV(2), .SCR_H(10), .PADDLE_Y(6),
                 .PADDLE_W(255), .X_INIT(50), .Y_INIT(2)) dut_e (
      .clk(clk), .resetn(resetn), .bus(ife), .state_dbg(st_e));

   ball_state_t cur_st;
   logic [7:0]  cur_x;
   logic [6:0]  cur_y;
   logic [2:0]  cur_c;
   logic        cur_plot, cur_busy, cur_done, cur_hit, cur_miss;

   always_comb begin
      cur_st = st_a; cur_x = ifa.x_out; cur_y = ifa.y_out; cur_c = ifa.color_out;
      cur_plot = ifa.plot; cur_busy = ifa.busy; cur_done = ifa.done;
      cur_hit = ifa.hit; cur_miss = ifa.miss;
      case (sel)
         1: begin
            cur_st = st_c; cur_x = ifc.x_out; cur_y = ifc.y_out; cur_c = ifc.color_out;
            cur_plot = ifc.plot; cur_busy = ifc.busy; cur_done = ifc.done;
            cur_hit = ifc.hit; cur_miss = ifc.miss;
         end
         2: begin
            cur_st = st_d; cur_x = ifd.x_out; cur_y = ifd.y_out; cur_c = ifd.color_out;
            cur_plot = ifd.plot; cur_busy = ifd.busy; cur_done = ifd.done;
            cur_hit = ifd.hit; cur_miss = ifd.miss;
         end
         3: begin
            cur_st = st_e; cur_x = ife.x_out; cur_y = ife.y_out; cur_c = ife.color_out;
            cur_plot = ife.plot; cur_busy = ife.busy; cur_done = ife.done;
            cur_hit = ife.hit; cur_miss = ife.miss;
         end
         default: ;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   task automatic drive_go(input logic v);
      ifa.go = v && (sel == 0);
      ifc.go = v && (sel == 1);
      ifd.go = v && (sel == 2);
      ife.go = v && (sel == 3);
   endtask

   task automatic do_reset();
      drive_go(1'b0);
      @(negedge clk);
      resetn = 1'b0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
   endtask

   // One frame: erase origin (ex,ey), draw origin (nx,ny), draw colour, done cycle, pulse counts.
   task automatic run_frame(input bit hold, input int ex, input int ey, input int nx, input int ny,
                            input int col, input int exp_len, input int exp_hit, input int exp_miss,
                            input string tag);
      int len, e_cnt, e_bad, d_cnt, d_bad, h_cnt, m_cnt, b_bad;
      len = -1; e_cnt = 0; e_bad = 0; d_cnt = 0; d_bad = 0; h_cnt = 0; m_cnt = 0; b_bad = 0;
      @(negedge clk);
      drive_go(1'b1);
      for (int cyc = 1; cyc <= 200 && len < 0; cyc++) begin
         @(negedge clk);
         if (!hold) drive_go(1'b0);
         if (cur_busy !== 1'b1) b_bad++;
         if (cur_plot === 1'b1) begin
            if (cur_c === 3'd0) begin
               if (cur_x !== 8'(ex + e_cnt % 4) || cur_y !== 7'(ey + e_cnt / 4) || cyc != 1 + e_cnt)
                  e_bad++;
               e_cnt++;
            end else begin
               if (cur_x !== 8'(nx + d_cnt % 4) || cur_y !== 7'(ny + d_cnt / 4) ||
                   cur_c !== 3'(col) || cyc != exp_len - 16 + d_cnt)
                  d_bad++;
               d_cnt++;
            end
         end
         if (cur_hit === 1'b1) h_cnt += (cyc == exp_len - 17) ? 1 : 100;
         if (cur_miss === 1'b1) m_cnt += (cyc == exp_len - 17) ? 1 : 100;
         if (cur_done === 1'b1) len = cyc;
      end
      chk($sformatf("%s_done_cycle", tag), len, exp_len);
      chk($sformatf("%s_busy", tag), b_bad, 0);
      chk($sformatf("%s_erase_cnt", tag), e_cnt, 16);
      chk($sformatf("%s_erase_pix", tag), e_bad, 0);
      chk($sformatf("%s_draw_cnt", tag), d_cnt, 16);
      chk($sformatf("%s_draw_pix", tag), d_bad, 0);
      chk($sformatf("%s_hit", tag), h_cnt, exp_hit);
      chk($sformatf("%s_miss", tag), m_cnt, exp_miss);
   endtask

   int xs_d[8] = '{3, 4, 3, 2, 1, 0, 1, 2};
   int ys_e[19] = '{2, 1, 0, 1, 2, 1, 0, 1, 2, 1, 0, 1, 2, 3, 4, 5, 6, 2, 1};

   initial begin
      int per_e, ex_e, nx_e;
      ifa.paddle_x = 8'd0; ifc.paddle_x = 8'd0; ifd.paddle_x = 8'd0; ife.paddle_x = 8'd0;
      drive_go(1'b0);
      resetn = 1'b0;
      repeat (3) @(negedge clk);

      chk("rst_state", cur_st, ST_IDLE);
      chk("rst_plot", cur_plot, 1'b0);
      chk("rst_busy", cur_busy, 1'b0);
      chk("rst_done", cur_done, 1'b0);
      chk("rst_hit", cur_hit, 1'b0);
      chk("rst_miss", cur_miss, 1'b0);
      chk("rst_color", cur_c, 3'd0);
      chk("rst_x", cur_x, 8'd50);
      chk("rst_y", cur_y, 7'd60);
      resetn = 1'b1;

      // Single frame from (50,60) to (51,61), colour 1, done at cycle 38.
      run_frame(1'b0, 50, 60, 51, 61, 1, 38, 0, 0, "single");
      chk("idle_x", cur_x, 8'd51);

      // Asynchronous reset in the middle of a draw sweep.
      @(negedge clk);
      drive_go(1'b1);
      @(negedge clk);
      drive_go(1'b0);
      for (int i = 0; i < 60 && cur_st !== ST_DRAW; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      chk("middraw_state", cur_st, ST_DRAW);
      chk("middraw_plot", cur_plot, 1'b1);
      chk("middraw_color", cur_c, 3'd2);
      #1 resetn = 1'b0;
      #1;
      chk("async_state", cur_st, ST_IDLE);
      chk("async_plot", cur_plot, 1'b0);
      chk("async_busy", cur_busy, 1'b0);
      chk("async_x", cur_x, 8'd50);
      chk("async_y", cur_y, 7'd60);
      chk("async_color", cur_c, 3'd0);
      @(negedge clk);
      resetn = 1'b1;

      // go held high: seven back-to-back frames, colours 1..6 then 1.
      for (int n = 1; n <= 7; n++)
         run_frame(1'b1, 49 + n, 59 + n, 50 + n, 60 + n, (n - 1) % 6 + 1, 38, 0, 0,
                   $sformatf("b2b_f%0d", n));
      drive_go(1'b0);

      // Paddle hit at by=105 (bx=95, paddle 93..108).
      do_reset();
      ifa.paddle_x = 8'd93;
      for (int n = 1; n <= 45; n++)
         run_frame(1'b0, 49 + n, 59 + n, 50 + n, 60 + n, (n - 1) % 6 + 1, 38, 0, 0,
                   $sformatf("hitdesc_f%0d", n));
      run_frame(1'b0, 95, 105, 96, 104, 4, 38, 1, 0, "paddle_hit");
      run_frame(1'b0, 96, 104, 97, 103, 5, 38, 0, 0, "after_hit");

      // Paddle out of reach: descend to by=116, then miss and respawn moving up.
      do_reset();
      ifa.paddle_x = 8'd100;
      for (int n = 1; n <= 56; n++)
         run_frame(1'b0, 49 + n, 59 + n, 50 + n, 60 + n, (n - 1) % 6 + 1, 38, 0, 0,
                   $sformatf("missdesc_f%0d", n));
      run_frame(1'b0, 106, 116, 50, 60, 3, 38, 0, 1, "miss");
      run_frame(1'b0, 50, 60, 51, 59, 4, 38, 0, 0, "after_miss");

      // Right wall: bx=156 bounces to 155 then keeps moving left.
      sel = 1;
      do_reset();
      run_frame(1'b0, 156, 10, 155, 11, 1, 35, 0, 0, "rwall_1");
      run_frame(1'b0, 155, 11, 154, 12, 2, 35, 0, 0, "rwall_2");

      // Narrow screen: right bounce, run to bx=0, left bounce to 1.
      sel = 2;
      do_reset();
      for (int n = 1; n <= 7; n++)
         run_frame(1'b0, xs_d[n-1], 9 + n, xs_d[n], 10 + n, (n - 1) % 6 + 1, 35, 0, 0,
                   $sformatf("lwall_f%0d", n));

      // Short field with wide paddle: hits at frames 1,5,9; paddle moved away, miss at 17.
      sel = 3;
      do_reset();
      ife.paddle_x = 8'd0;
      for (int n = 1; n <= 18; n++) begin
         if (n == 13) ife.paddle_x = 8'd200;
`ifdef BALL_SPEEDUP_EN
         per_e = (n == 1) ? 8 : (n <= 5) ? 4 : (n <= 17) ? 2 : 8;
`else
         per_e = 8;
`endif
         ex_e = (n <= 17) ? 49 + n : 50;
         nx_e = (n < 17) ? 50 + n : (n == 17) ? 50 : 51;
         run_frame(1'b0, ex_e, ys_e[n-1], nx_e, ys_e[n], (n - 1) % 6 + 1, 34 + per_e,
                   (n == 1 || n == 5 || n == 9) ? 1 : 0, (n == 17) ? 1 : 0,
                   $sformatf("period_f%0d", n));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
